// File: rtl/ir_key_handler.sv
// ir_key_handler: turns decoded NEC IR frames and repeat strobes into clean
// key events (press pulse, held level, release pulse), counts corrupt
// frames and shows the current command byte on two active-low 7-seg digits.
//
// Optional feature macro: AUTOREPEAT_EN
//   defined   -> while a key is held, key_press re-fires after
//                AUTOREPEAT_DELAY cycles and then every AUTOREPEAT_RATE cycles.
//   undefined -> key_press fires only on accepted frames.
module ir_key_handler #(
    parameter int          HOLD_TIMEOUT     = 7500000,
    parameter int          STRICT_ADDR      = 1,
    parameter int          ADDR_CHECK       = 0,
    parameter logic [7:0]  ADDR_MATCH       = 8'h00,
    parameter int          AUTOREPEAT_DELAY = 25000000,
    parameter int          AUTOREPEAT_RATE  = 5000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [31:0] frame_data,
    input  logic        frame_valid,
    input  logic        repeat_valid,
    output logic [7:0]  key_code,
    output logic [7:0]  key_addr,
    output logic        key_press,
    output logic        key_held,
    output logic        key_release,
    output logic [7:0]  err_count,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1
);

    localparam int              HT_W      = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [HT_W-1:0] HOLD_LAST = HT_W'(HOLD_TIMEOUT - 1);
    localparam logic [6:0]      SEG_ZERO  = 7'b1000000;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Active-low hex digit encoder, segments ordered g..a, lowercase b and d.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      key_code_q, key_code_d;
    logic [7:0]      key_addr_q, key_addr_d;
    logic            press_q, press_d;
    logic            held_q, held_d;
    logic            release_q, release_d;
    logic [7:0]      err_q, err_d;
    logic [HT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]      hex0_q, hex0_d;
    logic [6:0]      hex1_q, hex1_d;

    logic cmd_ok_s;
    logic addr_ok_s;
    logic clean_s;
    logic match_s;
    logic accept_s;
    logic corrupt_s;
    logic expire_s;

    // Frame integrity: command must be complemented; address too in strict mode.
    assign cmd_ok_s  = (frame_data[31:24] == ~frame_data[23:16]);
    assign addr_ok_s = (STRICT_ADDR == 0) || (frame_data[15:8] == ~frame_data[7:0]);
    assign clean_s   = cmd_ok_s && addr_ok_s;
    assign match_s   = (ADDR_CHECK == 0) || (frame_data[7:0] == ADDR_MATCH);
    assign accept_s  = frame_valid && clean_s && match_s;
    assign corrupt_s = frame_valid && !clean_s;

    // A held key times out only when no accepted frame or repeat arrives on the terminal cycle.
    assign expire_s  = (state_q == HELD) && !accept_s && !repeat_valid && (hold_cnt_q == HOLD_LAST);

`ifdef AUTOREPEAT_EN
    localparam int               RPT_MAX    = (AUTOREPEAT_DELAY > AUTOREPEAT_RATE) ?
                                              AUTOREPEAT_DELAY : AUTOREPEAT_RATE;
    localparam int               RPT_W      = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(AUTOREPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(AUTOREPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_run_q, rpt_run_d;   // 0: waiting initial delay, 1: periodic phase
    logic [RPT_W-1:0] rpt_last_s;

    assign rpt_last_s = rpt_run_q ? RATE_LAST : DELAY_LAST;
`else
    logic unused_rpt_cfg_s;
    assign unused_rpt_cfg_s = ^{AUTOREPEAT_DELAY, AUTOREPEAT_RATE};
`endif

    // Next-state and output decode for the key FSM, error counter and timers.
    always_comb begin
        state_d    = state_q;
        key_code_d = key_code_q;
        key_addr_d = key_addr_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;
`ifdef AUTOREPEAT_EN
        rpt_cnt_d  = rpt_cnt_q;
        rpt_run_d  = rpt_run_q;
`endif

        if (corrupt_s && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
`ifdef AUTOREPEAT_EN
                rpt_cnt_d  = '0;
                rpt_run_d  = 1'b0;
`endif
                if (accept_s) begin
                    key_code_d = frame_data[23:16];
                    key_addr_d = frame_data[7:0];
                    press_d    = 1'b1;
                    held_d     = 1'b1;
                    state_d    = HELD;
                end else begin
                    held_d     = 1'b0;
                end
            end
            HELD: begin
                if (accept_s) begin
                    key_code_d = frame_data[23:16];
                    key_addr_d = frame_data[7:0];
                    press_d    = 1'b1;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
`ifdef AUTOREPEAT_EN
                    rpt_cnt_d  = '0;
                    rpt_run_d  = 1'b0;
`endif
                end else if (expire_s) begin
                    release_d  = 1'b1;
                    held_d     = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
`ifdef AUTOREPEAT_EN
                    rpt_cnt_d  = '0;
                    rpt_run_d  = 1'b0;
`endif
                end else begin
                    if (repeat_valid) begin
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HT_W'(1);
                    end
`ifdef AUTOREPEAT_EN
                    // Release has already been ruled out here, so a due pulse is safe.
                    if (rpt_cnt_q == rpt_last_s) begin
                        press_d   = 1'b1;
                        rpt_cnt_d = '0;
                        rpt_run_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d    = IDLE;
                held_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase

        hex0_d = seg7(key_code_q[3:0]);
        hex1_d = seg7(key_code_q[7:4]);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            key_code_q <= 8'h00;
            key_addr_q <= 8'h00;
            press_q    <= 1'b0;
            held_q     <= 1'b0;
            release_q  <= 1'b0;
            err_q      <= 8'h00;
            hold_cnt_q <= '0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= SEG_ZERO;
        end else begin
            state_q    <= state_d;
            key_code_q <= key_code_d;
            key_addr_q <= key_addr_d;
            press_q    <= press_d;
            held_q     <= held_d;
            release_q  <= release_d;
            err_q      <= err_d;
            hold_cnt_q <= hold_cnt_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
        end
    end

`ifdef AUTOREPEAT_EN
    // Auto-repeat timer registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rpt_cnt_q <= '0;
            rpt_run_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_run_q <= rpt_run_d;
        end
    end
`endif

    assign key_code    = key_code_q;
    assign key_addr    = key_addr_q;
    assign key_press   = press_q;
    assign key_held    = held_q;
    assign key_release = release_q;
    assign err_count   = err_q;
    assign HEX0        = hex0_q;
    assign HEX1        = hex1_q;

endmodule

// File: tb/tb_ir_key_handler.sv
// Self-checking bench for ir_key_handler (HOLD_TIMEOUT=100, address filter on,
// auto-repeat timing 20/10 when AUTOREPEAT_EN is defined).
module tb_ir_key_handler;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        repeat_valid;
    logic [7:0]  key_code;
    logic [7:0]  key_addr;
    logic        key_press;
    logic        key_held;
    logic        key_release;
    logic [7:0]  err_count;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;

    always #5 CLOCK_50 = ~CLOCK_50;

    ir_key_handler #(
        .HOLD_TIMEOUT    (100),
        .STRICT_ADDR     (1),
        .ADDR_CHECK      (1),
        .ADDR_MATCH      (8'h00),
        .AUTOREPEAT_DELAY(20),
        .AUTOREPEAT_RATE (10)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .repeat_valid(repeat_valid),
        .key_code    (key_code),
        .key_addr    (key_addr),
        .key_press   (key_press),
        .key_held    (key_held),
        .key_release (key_release),
        .err_count   (err_count),
        .HEX0        (HEX0),
        .HEX1        (HEX1)
    );

    typedef struct packed {
        logic       press;
        logic       held;
        logic       rel;
        logic [7:0] code;
        logic [7:0] err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Expected auto-repeat pulse k cycles after the last accepted frame.
    function automatic logic ar_pulse(input int k);
`ifdef AUTOREPEAT_EN
        return (k >= 20) && (((k - 20) % 10) == 0);
`else
        return (k < 0);
`endif
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        RESET        = 1'b1;
        frame_data   = 32'h0;
        frame_valid  = 1'b0;
        repeat_valid = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({key_press, key_held, key_release, key_code, key_addr, err_count, HEX1, HEX0} !==
            {3'b000, 8'h00, 8'h00, 8'h00, 7'b1000000, 7'b1000000}) begin
            miscompares++;
            $display("FAIL reset: got p/h/r=%b%b%b code=%h addr=%h err=%0d hex1=%b hex0=%b, want all zero and hex 1000000",
                     key_press, key_held, key_release, key_code, key_addr, err_count, HEX1, HEX0);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_valid_press();
        frame_data  = 32'hBA45FF00;
        frame_valid = 1'b1;
        sb.push_back('{1'b1, 1'b1, 1'b0, 8'h45, 8'h00});
        tick();
        frame_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} ||
            key_code !== e.code || err_count !== e.err || key_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL press: got p/h/r=%b%b%b code=%h addr=%h err=%0d, want %b%b%b code=%h addr=00 err=%0d",
                     key_press, key_held, key_release, key_code, key_addr, err_count, e.press, e.held, e.rel, e.code, e.err);
        end
        sb.push_back('{1'b0, 1'b1, 1'b0, 8'h45, 8'h00});
        tick();
        e = sb.pop_front();
        vectors++;
        if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} || key_code !== e.code) begin
            miscompares++;
            $display("FAIL press_end: got p/h/r=%b%b%b code=%h, want %b%b%b code=%h",
                     key_press, key_held, key_release, key_code, e.press, e.held, e.rel, e.code);
        end
        vectors++;
        if ({HEX1, HEX0} !== {7'b0011001, 7'b0010010}) begin
            miscompares++;
            $display("FAIL hex_45: got hex1=%b hex0=%b, want 0011001 0010010", HEX1, HEX0);
        end
    endtask

    // Continues from the press (edge 0): repeats at 80/160/240, release at 340.
    task automatic test_hold_release();
        for (int k = 2; k <= 345; k++) begin
            repeat_valid = (k == 80) || (k == 160) || (k == 240);
            sb.push_back('{ar_pulse(k) && (k < 340), (k < 340), (k == 340), 8'h45, 8'h00});
            tick();
            repeat_valid = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} || key_code !== e.code) begin
                miscompares++;
                $display("FAIL hold k=%0d: got p/h/r=%b%b%b code=%h, want %b%b%b code=%h",
                         k, key_press, key_held, key_release, key_code, e.press, e.held, e.rel, e.code);
            end
        end
    endtask

    task automatic test_key_change();
        for (int k = 0; k <= 4; k++) begin
            frame_valid  = (k == 0) || (k == 4);
            repeat_valid = (k == 4);
            frame_data   = (k == 4) ? 32'hE718FF00 : 32'hBA45FF00;
            if (k == 0) begin
                sb.push_back('{1'b1, 1'b1, 1'b0, 8'h45, 8'h00});
            end else if (k == 4) begin
                sb.push_back('{1'b1, 1'b1, 1'b1, 8'h18, 8'h00});
            end else begin
                sb.push_back('{1'b0, 1'b1, 1'b0, 8'h45, 8'h00});
            end
            tick();
            frame_valid  = 1'b0;
            repeat_valid = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} ||
                key_code !== e.code || key_addr !== 8'h00) begin
                miscompares++;
                $display("FAIL change k=%0d: got p/h/r=%b%b%b code=%h addr=%h, want %b%b%b code=%h addr=00",
                         k, key_press, key_held, key_release, key_code, key_addr, e.press, e.held, e.rel, e.code);
            end
        end
        for (int j = 1; j <= 102; j++) begin
            sb.push_back('{ar_pulse(j) && (j < 100), (j < 100), (j == 100), 8'h18, 8'h00});
            tick();
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} || key_code !== e.code) begin
                miscompares++;
                $display("FAIL change_hold j=%0d: got p/h/r=%b%b%b code=%h, want %b%b%b code=%h",
                         j, key_press, key_held, key_release, key_code, e.press, e.held, e.rel, e.code);
            end
            if (j == 1) begin
                vectors++;
                if ({HEX1, HEX0} !== {7'b1111001, 7'b0000000}) begin
                    miscompares++;
                    $display("FAIL hex_18: got hex1=%b hex0=%b, want 1111001 0000000", HEX1, HEX0);
                end
            end
        end
    endtask

    task automatic test_addr_check();
        for (int k = 0; k < 3; k++) begin
            frame_data  = 32'hBA45FE01;
            frame_valid = (k == 0);
            sb.push_back('{1'b0, 1'b0, 1'b0, 8'h18, 8'h00});
            tick();
            frame_valid = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} ||
                key_code !== e.code || err_count !== e.err) begin
                miscompares++;
                $display("FAIL addr_filter k=%0d: got p/h/r=%b%b%b code=%h err=%0d, want %b%b%b code=%h err=%0d",
                         k, key_press, key_held, key_release, key_code, err_count, e.press, e.held, e.rel, e.code, e.err);
            end
        end
    endtask

    task automatic test_corrupt();
        logic [7:0] cmd;
        logic [7:0] adr;
        logic [7:0] x;
        for (int i = 1; i <= 257; i++) begin
            cmd = 8'($urandom);
            adr = 8'($urandom);
            x   = 8'($urandom_range(1, 255));
            if (i == 1) begin
                frame_data = 32'hBB45FF00;
            end else if ((i % 2) == 1) begin
                frame_data = {~cmd, cmd, ~adr ^ x, adr};
            end else begin
                frame_data = {~cmd ^ x, cmd, ~adr, adr};
            end
            frame_valid = (i <= 256);
            sb.push_back('{1'b0, 1'b0, 1'b0, 8'h18, (i > 255) ? 8'd255 : 8'(i)});
            tick();
            frame_valid = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} ||
                key_code !== e.code || err_count !== e.err) begin
                miscompares++;
                $display("FAIL corrupt i=%0d: got p/h/r=%b%b%b code=%h err=%0d, want %b%b%b code=%h err=%0d",
                         i, key_press, key_held, key_release, key_code, err_count, e.press, e.held, e.rel, e.code, e.err);
            end
        end
    endtask

`ifdef AUTOREPEAT_EN
    task automatic test_autorepeat();
        for (int k = 0; k <= 45; k++) begin
            frame_data  = 32'hBA45FF00;
            frame_valid = (k == 0);
            sb.push_back('{(k == 0) || (k == 20) || (k == 30) || (k == 40), 1'b1, 1'b0, 8'h45, 8'd255});
            tick();
            frame_valid = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({key_press, key_held, key_release} !== {e.press, e.held, e.rel} || key_code !== e.code) begin
                miscompares++;
                $display("FAIL autorepeat k=%0d: got p/h/r=%b%b%b code=%h, want %b%b%b code=%h",
                         k, key_press, key_held, key_release, key_code, e.press, e.held, e.rel, e.code);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_held();
        frame_data  = 32'hBA45FF00;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        vectors++;
        if (key_held !== 1'b1 || key_code !== 8'h45 || err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL pre_reset: got held=%b code=%h err=%0d, want 1 45 255", key_held, key_code, err_count);
        end
        #2;
        RESET = 1'b1;
        #1;
        vectors++;
        if ({key_press, key_held, key_release, key_code, key_addr, err_count, HEX1, HEX0} !==
            {3'b000, 8'h00, 8'h00, 8'h00, 7'b1000000, 7'b1000000}) begin
            miscompares++;
            $display("FAIL async_reset: got p/h/r=%b%b%b code=%h addr=%h err=%0d hex1=%b hex0=%b, want all zero and hex 1000000",
                     key_press, key_held, key_release, key_code, key_addr, err_count, HEX1, HEX0);
        end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_valid_press();
        test_hold_release();
        test_key_change();
        test_addr_check();
        test_corrupt();
`ifdef AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_reset_mid_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ir_key_handler.md
Name: ir_key_handler

Overview:
Downstream consumer of the NEC IR frame decoder on the DE2 board. It accepts each decoded 32-bit frame and each NEC repeat-code strobe, and validates the address and command bytes. It turns them into clean key events (press pulse, held level, release pulse), counts corrupt frames and drives the current command byte onto two active-low 7-segment digits.

Parameters:
HOLD_TIMEOUT, 7500000, cycles without a frame or repeat before a held key is released (150 ms at 50 MHz).
STRICT_ADDR, 1, 1 = require frame[15:8] == ~frame[7:0]; 0 = accept extended 16-bit addresses.
ADDR_CHECK, 0, 1 = accept only frames whose frame[7:0] == ADDR_MATCH.
ADDR_MATCH, 8'h00, remote address accepted when ADDR_CHECK=1.
AUTOREPEAT_DELAY, 25000000, cycles from press to first auto-repeat pulse (AUTOREPEAT_EN only).
AUTOREPEAT_RATE, 5000000, cycles between later auto-repeat pulses (AUTOREPEAT_EN only).

Ports:
CLOCK_50  input  1  50 MHz system clock; all state on its rising edge.
RESET  input  1  asynchronous, active-high reset.
frame_data  input  32  decoded frame: [7:0] addr, [15:8] ~addr or addr high, [23:16] cmd, [31:24] ~cmd.
frame_valid  input  1  one-cycle strobe; frame_data is stable during the strobe cycle.
repeat_valid  input  1  one-cycle strobe for each NEC repeat code (lead burst + 2.25 ms space).
key_code  output  8  command byte of the last accepted frame.
key_addr  output  8  address byte of the last accepted frame.
key_press  output  1  one-cycle pulse per accepted press (and per auto-repeat).
key_held  output  1  high while a key is considered held.
key_release  output  1  one-cycle pulse when a held key ends.
err_count  output  8  saturating count of rejected (corrupt) frames.
HEX0  output  7  active-low segments g..a, key_code[3:0] as hex.
HEX1  output  7  active-low segments g..a, key_code[7:4] as hex.

Behaviour:
- Reset (async, immediate): state IDLE; key_code, key_addr and err_count are 0; key_press, key_held and key_release are 0; timers are 0; HEX0 and HEX1 are 7'b1000000 ("0").
- Frame is valid when frame[31:24] == ~frame[23:16]. It must also meet the STRICT_ADDR rule when that is 1.
- A valid frame is corrupt-free. Failing any of these checks makes it corrupt.
- When ADDR_CHECK=1, a corrupt-free frame with addr != ADDR_MATCH is silently ignored. It is not counted as an error.
- Corrupt frame: err_count += 1 and saturates at 255. State, timers and outputs are otherwise unchanged.
- All outputs are registered. Pulses appear on the cycle after the input strobe (latency 1).
- HEX outputs follow key_code with one further register stage (latency 2 from frame_valid).
- FSM, two states:
  - IDLE: accepted frame -> latch code and addr, key_press=1, key_held=1, hold timer=0, go to HELD. repeat_valid is ignored.
  - HELD: repeat_valid -> hold timer=0.
  - HELD: accepted frame, same or different code -> key_release=1 and key_press=1 in the same cycle; latch the new code and addr; hold timer=0; stay in HELD.
  - HELD: hold timer increments every cycle. When it reaches HOLD_TIMEOUT-1 with no strobe in that cycle -> key_release=1, key_held=0, go to IDLE. key_code holds its last value.
- Simultaneous frame_valid and repeat_valid: frame_valid wins, repeat is ignored.
- A strobe on the exact timeout cycle: the strobe wins and no release is generated.
- Hold timer width is $clog2(HOLD_TIMEOUT+1). It never wraps; it stops at the terminal value.
- Segment encoding is standard hex 0-F on active-low segments, with lowercase b and d.

Optional Feature:
AUTOREPEAT_EN:
- Defined: in HELD, a repeat timer starts at the press. key_press pulses once after AUTOREPEAT_DELAY cycles, then every AUTOREPEAT_RATE cycles while key_held=1.
- The repeat timer resets on every accepted frame and on entry to IDLE.
- Auto-repeat pulses never coincide with key_release. If both fall on the same cycle, release wins and the pulse is dropped.
- Undefined: key_press fires only on accepted frames. The repeat timer and its logic are absent.

Test Plan:
- Reset mid-HELD: assert RESET asynchronously -> all outputs return to reset values in the same cycle, without waiting for a clock edge. HEX0 and HEX1 = 7'b1000000.
- Valid press: HOLD_TIMEOUT=100, frame_data=32'hBA45FF00 strobed -> next cycle key_press=1 for one cycle, key_code=8'h45, key_addr=8'h00, key_held=1. Two cycles after the strobe, HEX1=7'b0011001 ("4") and HEX0=7'b0010010 ("5").
- Hold and release: after the press, repeat_valid every 80 cycles ×3 -> key_held stays 1. Then no strobes -> key_release pulses exactly 100 cycles after the last repeat strobe, and key_held=0.
- Corrupt frames: frame_data=32'hBB45FF00, then 255 more corrupt frames -> err_count=1, then saturates at 255. No key_press at any point.
- Key change while held: in HELD with 8'h45, strobe 32'hE718FF00 together with repeat_valid -> key_release and key_press both pulse on the same cycle, and key_code=8'h18.
- ADDR_CHECK=1, ADDR_MATCH=8'h00: strobe 32'hBA45FE01 -> no event and err_count unchanged. With AUTOREPEAT_EN, AUTOREPEAT_DELAY=20 and AUTOREPEAT_RATE=10, holding a press -> key_press at +1, +21, +31, +41 cycles.
